// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a multi-digit BCD display: walks the digits
// with a blanking gap, suppresses leading zeros and swaps values only at frame boundaries.
module seg_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GAP      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  w,
  output logic                  x,
  output logic                  y,
  output logic                  z,
  output logic [DIGITS-1:0]     an,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > GAP) ? $clog2(PRESCALE) : $clog2(GAP);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_d;
  logic [4*DIGITS-1:0]   pending_q, shadow_q, shadow_d;
  logic [DIGITS-1:0]     an_d;
  logic [3:0]            nib_d;
  logic                  tick_d;

  function automatic logic [3:0] nib_at(input logic [4*DIGITS-1:0] v, input logic [2:0] i);
    nib_at = '0;
    for (int k = 0; k < DIGITS; k++)
      if (i == 3'(k)) nib_at = v[4*k +: 4];
  endfunction

  // True when digit i and every digit above it are zero.
  function automatic logic upper_zero(input logic [4*DIGITS-1:0] v, input logic [2:0] i);
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      if (3'(k) >= i && v[4*k +: 4] != 4'd0) upper_zero = 1'b0;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = digit_idx;
    shadow_d = shadow_q;
    unique case (state_q)
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
          if (digit_idx == IDX_LAST) begin
            idx_d    = '0;
            // A load landing on the boundary cycle beats the older pending value.
            shadow_d = load ? digits_in : pending_q;
          end else begin
            idx_d = digit_idx + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    nib_d  = nib_at(shadow_d, idx_d);
    tick_d = (state_d == S_SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    an_d   = '1;
    if (state_d == S_SHOW && !(blank_lz && idx_d != 3'd0 && upper_zero(shadow_d, idx_d)))
      for (int k = 0; k < DIGITS; k++)
        if (idx_d == 3'(k)) an_d[k] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_GAP;
      cnt_q      <= '0;
      digit_idx  <= '0;
      pending_q  <= '0;
      shadow_q   <= '0;
      an         <= '1;
      {w, x, y, z} <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_idx  <= idx_d;
      shadow_q   <= shadow_d;
      if (load) pending_q <= digits_in;
      an         <= an_d;
      {w, x, y, z} <= nib_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized self-checking bench for seg_scan_mux, compared against a
// frame-position model (DIGITS=4, PRESCALE=4, GAP=1: 5-cycle slots, 20-cycle frames).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        w, x, y, z, frame_tick;
  logic [3:0]  an;
  logic [2:0]  digit_idx;

  int checks = 0;
  int failures = 0;

  // Model: cycle number within the run plus the pending/displayed values.
  int          m_c;
  logic [15:0] m_pend, m_shown;
  logic        m_lz;

  seg_scan_mux #(.DIGITS(4), .PRESCALE(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blank_lz(blank_lz),
    .w(w), .x(x), .y(y), .z(z), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Expected {an, digit_idx, wxyz, frame_tick} from position in the frame.
  function automatic logic [11:0] model_vec();
    int slot = (m_c % 20) / 5;
    int pos  = m_c % 5;
    logic [3:0] nib = 4'((m_shown >> (4 * slot)) & 16'hF);
    logic supp = m_lz && slot != 0 && ((m_shown >> (4 * slot)) == 16'd0);
    logic [3:0] a = (pos != 0 && !supp) ? ~(4'd1 << slot) : 4'hF;
    return {a, 3'(slot), nib, (m_c % 20) == 19};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {an, digit_idx, w, x, y, z, frame_tick};
  endfunction

  task automatic tick(input logic ld, input logic [15:0] d, input logic blz, input logic r);
    load = ld; digits_in = d; blank_lz = blz; rst = r;
    @(posedge clk);
    if (r) begin
      m_c = 0; m_pend = '0; m_shown = '0;
    end else begin
      if (m_c % 20 == 19) m_shown = ld ? d : m_pend;
      if (ld) m_pend = d;
      m_c++;
    end
    m_lz = blz;
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (an !== 4'hF || {w, x, y, z} !== 4'd0 || frame_tick !== 1'b0 || digit_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_values got an=%b wxyz=%b ft=%b idx=%0d want an=1111 wxyz=0000 ft=0 idx=0",
               an, {w, x, y, z}, frame_tick, digit_idx);
    end
    for (int i = 1; i <= 60; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL reset_scan cycle=%0d got=%h want=%h", m_c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (an !== 4'hF || frame_tick !== 1'b0) begin // cycle 60 is the gap before digit 0
      failures++;
      $display("FAIL reset_scan_gap60 got an=%b ft=%b want an=1111 ft=0", an, frame_tick);
    end
  endtask

  task automatic test_frame_load();
    repeat (2) tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 45; i++) begin
      tick(m_c == 7, 16'h1234, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec() || (m_c < 20 && {w, x, y, z} !== 4'd0)) begin
        failures++;
        $display("FAIL frame_load cycle=%0d got=%h want=%h", m_c, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] old_v = 16'h5678;
    int leaks = 0;
    repeat (2) tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      if (m_c == 2)       tick(1'b1, 16'h5678, 1'b0, 1'b0);
      else if (m_c == 19) tick(1'b1, 16'h9012, 1'b0, 1'b0);
      else                tick(1'b0, '0, 1'b0, 1'b0);
      if (an != 4'hF && {w, x, y, z} == 4'((old_v >> (4 * digit_idx)) & 16'hF)) leaks++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL boundary_load cycle=%0d got=%h want=%h", m_c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (leaks != 0) begin
      failures++;
      $display("FAIL boundary_load_stale got %0d cycles showing 5678 want 0", leaks);
    end
  endtask

  task automatic test_lz();
    int en_count[4];
    repeat (2) tick(1'b0, '0, 1'b1, 1'b1);
    tick(1'b1, 16'h0040, 1'b1, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      while (m_c % 20 != 0) tick(1'b0, '0, 1'b1, 1'b0);
      en_count = '{0, 0, 0, 0};
      for (int i = 0; i < 20; i++) begin
        tick(pass == 0 && i == 3, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) en_count[k]++;
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++;
          $display("FAIL lz pass=%0d cycle=%0d got=%h want=%h", pass, m_c, dut_vec(), model_vec());
        end
      end
      // Frame 0040: digits 0,1 enabled; frame 0000: digit 0 only. Window spans cycle 1..20.
      checks++;
      if (pass == 0 ? (en_count[0] != 4 || en_count[1] != 4 || en_count[2] != 0 || en_count[3] != 0)
                    : (en_count[0] != 4 || en_count[1] != 0 || en_count[2] != 0 || en_count[3] != 0)) begin
        failures++;
        $display("FAIL lz_enables pass=%0d got %0d,%0d,%0d,%0d (d0..d3)", pass,
                 en_count[0], en_count[1], en_count[2], en_count[3]);
      end
    end
  endtask

  task automatic test_mid_reset();
    repeat (2) tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 16'h8765, 1'b0, 1'b0);
    while (m_c != 32) tick(1'b0, '0, 1'b0, 1'b0); // SHOW of digit 2, second frame
    checks++;
    if (an !== 4'b1011 || {w, x, y, z} !== 4'd7) begin
      failures++;
      $display("FAIL mid_reset_pre got an=%b wxyz=%h want an=1011 wxyz=7", an, {w, x, y, z});
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (an !== 4'hF || digit_idx !== 3'd0 || {w, x, y, z} !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got an=%b idx=%0d wxyz=%b want an=1111 idx=0 wxyz=0000",
               an, digit_idx, {w, x, y, z});
    end
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL mid_reset_scan cycle=%0d got=%h want=%h", m_c, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    int loads = 0, ones_run = 0, prev_en = -1, bad = 0;
    logic blz = 1'b0;
    repeat (2) tick(1'b0, '0, 1'b0, 1'b1);
    while (loads < 1000) begin
      logic ld = ($urandom_range(0, 2) == 0);
      logic [15:0] d;
      for (int k = 0; k < 4; k++) d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 7) == 0) blz = ~blz;
      tick(ld, d, blz, 1'b0);
      if (ld) loads++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        if (bad++ < 10) $display("FAIL random cycle=%0d got=%h want=%h", m_c, dut_vec(), model_vec());
      end
      checks++;
      if ($countones(~an) > 1 || (an != 4'hF && (~an != (4'd1 << digit_idx)))) begin
        failures++;
        if (bad++ < 10) $display("FAIL invariant_onehot cycle=%0d got an=%b idx=%0d", m_c, an, digit_idx);
      end
      if (an == 4'hF) ones_run++;
      else begin
        checks++;
        if (prev_en >= 0 && int'(digit_idx) != prev_en && ones_run < 1) begin
          failures++;
          if (bad++ < 10) $display("FAIL invariant_gap cycle=%0d got gap=%0d want>=1", m_c, ones_run);
        end
        prev_en = int'(digit_idx);
        ones_run = 0;
      end
    end
  endtask

  initial begin
    m_c = 0; m_pend = '0; m_shown = '0; m_lz = 1'b0;
    test_reset();
    test_frame_load();
    test_back_to_back();
    test_lz();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
